// File: rtl/lb_wfifo.sv
// Small synchronous FIFO for deferred sequencer writes.
// The head entry is visible on dout while the FIFO is non-empty.
// Push and pop may both occur in the same cycle, including when the FIFO is full.
module lb_wfifo #(
    parameter int width = 49,
    parameter int aw    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [aw:0]      level,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << aw;
    localparam logic [aw-1:0] PTR_ONE = 1;
    localparam logic [aw:0]   LVL_ONE = 1;

    logic [width-1:0] mem_q [DEPTH];
    logic [aw-1:0]    wr_ptr_q;
    logic [aw-1:0]    rd_ptr_q;
    logic [aw:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    // Level never exceeds DEPTH, so its top bit alone flags a full FIFO.
    assign full    = level_q[aw];
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];

    // Push is accepted when a slot is free or one is freed in the same cycle.
    // Pop is accepted only when there is an entry to remove.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/lb_write_merge.sv
// Merges host writes (priority) and sequencer writes (deferrable) onto one
// registered local-bus write port. Sequencer writes that lose arbitration
// wait in a small FIFO. They are dropped only when that FIFO is full, and
// each drop is counted.
module lb_write_merge #(
    parameter int aw      = 17,
    parameter int dw      = 32,
    parameter int fifo_aw = 2,
    parameter int cw      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [dw-1:0]      host_data,
    input  logic [aw-1:0]      host_addr,
    input  logic               host_write,
    input  logic [dw-1:0]      seq_data,
    input  logic [aw-1:0]      seq_addr,
    input  logic               seq_write,
    input  logic               overflow_clr,
    output logic [dw-1:0]      lbo_data,
    output logic [aw-1:0]      lbo_addr,
    output logic               lbo_write,
    output logic [fifo_aw:0]   fifo_level,
    output logic               overflow,
    output logic [cw-1:0]      overflow_count
);

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_HOST,
        SEL_FIFO,
        SEL_BYP
    } sel_e;

    localparam logic [cw-1:0] CNT_MAX = '1;
    localparam logic [cw-1:0] CNT_ONE = 1;

    sel_e              sel;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [aw+dw-1:0]  fifo_head;
    logic              drop;

    logic [dw-1:0]     lbo_data_q, lbo_data_d;
    logic [aw-1:0]     lbo_addr_q, lbo_addr_d;
    logic              lbo_write_q, lbo_write_d;
    logic              overflow_q;
    logic [cw-1:0]     overflow_count_q, overflow_count_d;

    lb_wfifo #(
        .width (aw + dw),
        .aw    (fifo_aw)
    ) u_wfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({seq_addr, seq_data}),
        .dout  (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Arbitration: host first, then the queued backlog. A direct sequencer
    // bypass is allowed only with an empty FIFO, which keeps sequencer order.
    always_comb begin
        sel = SEL_IDLE;
        if (host_write) begin
            sel = SEL_HOST;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
        end else if (seq_write) begin
            sel = SEL_BYP;
        end
    end

    // FIFO control. A sequencer write that is not bypassed is queued. It is
    // dropped only if the FIFO is full and the head is not leaving this
    // cycle, which can happen only while the host holds the bus.
    always_comb begin
        fifo_pop  = (sel == SEL_FIFO);
        fifo_push = seq_write && (sel != SEL_BYP) && (!fifo_full || fifo_pop);
        drop      = seq_write && host_write && fifo_full;
    end

    // Next output beat. Idle cycles drive zeros so no stale values stay on the bus.
    always_comb begin
        lbo_write_d = 1'b0;
        lbo_addr_d  = '0;
        lbo_data_d  = '0;
        case (sel)
            SEL_HOST: begin
                lbo_write_d = 1'b1;
                lbo_addr_d  = host_addr;
                lbo_data_d  = host_data;
            end
            SEL_FIFO: begin
                lbo_write_d = 1'b1;
                lbo_addr_d  = fifo_head[aw+dw-1:dw];
                lbo_data_d  = fifo_head[dw-1:0];
            end
            SEL_BYP: begin
                lbo_write_d = 1'b1;
                lbo_addr_d  = seq_addr;
                lbo_data_d  = seq_data;
            end
            default: begin
                lbo_write_d = 1'b0;
            end
        endcase
    end

    // Drop counter. It saturates instead of wrapping. A clear in the same
    // cycle as a drop still records that drop.
    always_comb begin
        overflow_count_d = overflow_count_q;
        if (overflow_clr) begin
            overflow_count_d = drop ? CNT_ONE : '0;
        end else if (drop && (overflow_count_q != CNT_MAX)) begin
            overflow_count_d = overflow_count_q + CNT_ONE;
        end
    end

    // Output and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lbo_write_q      <= 1'b0;
            lbo_addr_q       <= '0;
            lbo_data_q       <= '0;
            overflow_q       <= 1'b0;
            overflow_count_q <= '0;
        end else begin
            lbo_write_q      <= lbo_write_d;
            lbo_addr_q       <= lbo_addr_d;
            lbo_data_q       <= lbo_data_d;
            overflow_q       <= drop;
            overflow_count_q <= overflow_count_d;
        end
    end

    assign lbo_write      = lbo_write_q;
    assign lbo_addr       = lbo_addr_q;
    assign lbo_data       = lbo_data_q;
    assign overflow       = overflow_q;
    assign overflow_count = overflow_count_q;

endmodule

// File: tb/tb_lb_write_merge.sv
// Bench for lb_write_merge. It runs a default instance and a second instance
// with a 2-bit drop counter. Both instances get the same stimulus.
module tb_lb_write_merge;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int FAW = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] host_data;
    logic [AW-1:0] host_addr;
    logic          host_write;
    logic [DW-1:0] seq_data;
    logic [AW-1:0] seq_addr;
    logic          seq_write;
    logic          overflow_clr;

    logic [DW-1:0] lbo_data, lbo_data2;
    logic [AW-1:0] lbo_addr, lbo_addr2;
    logic          lbo_write, lbo_write2;
    logic [FAW:0]  fifo_level, fifo_level2;
    logic          overflow, overflow2;
    logic [7:0]    overflow_count;
    logic [1:0]    overflow_count2;

    lb_write_merge u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_data      (host_data),
        .host_addr      (host_addr),
        .host_write     (host_write),
        .seq_data       (seq_data),
        .seq_addr       (seq_addr),
        .seq_write      (seq_write),
        .overflow_clr   (overflow_clr),
        .lbo_data       (lbo_data),
        .lbo_addr       (lbo_addr),
        .lbo_write      (lbo_write),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .overflow_count (overflow_count)
    );

    lb_write_merge #(.cw(2)) u_dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_data      (host_data),
        .host_addr      (host_addr),
        .host_write     (host_write),
        .seq_data       (seq_data),
        .seq_addr       (seq_addr),
        .seq_write      (seq_write),
        .overflow_clr   (overflow_clr),
        .lbo_data       (lbo_data2),
        .lbo_addr       (lbo_addr2),
        .lbo_write      (lbo_write2),
        .fifo_level     (fifo_level2),
        .overflow       (overflow2),
        .overflow_count (overflow_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [FAW:0]  lvl;
        logic          ov;
        logic [7:0]    c8;
        logic [1:0]    c2;
    } exp_t;

    exp_t                exp_q[$];
    logic [AW+DW-1:0]    sq[$];
    logic [7:0]          m_c8;
    logic [1:0]          m_c2;
    int                  tests;
    int                  fails;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr"},   {63'd0, lbo_write}, 64'd0);
        chk({tag, "_addr"}, {47'd0, lbo_addr}, 64'd0);
        chk({tag, "_data"}, {32'd0, lbo_data}, 64'd0);
        chk({tag, "_lvl"},  {61'd0, fifo_level}, 64'd0);
        chk({tag, "_ov"},   {63'd0, overflow}, 64'd0);
        chk({tag, "_cnt"},  {56'd0, overflow_count}, 64'd0);
        chk({tag, "_cnt2"}, {62'd0, overflow_count2}, 64'd0);
    endtask

    // One clock cycle: drive the inputs, queue the expected output, and check it on the next falling edge.
    task automatic cycle(input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                         input logic sw, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                         input logic clr);
        exp_t e;
        logic drop;
        logic [AW+DW-1:0] h;
        host_write   = hw;
        host_addr    = ha;
        host_data    = hd;
        seq_write    = sw;
        seq_addr     = sa;
        seq_data     = sd;
        overflow_clr = clr;

        e.w = 1'b0; e.a = '0; e.d = '0;
        drop = 1'b0;
        if (hw) begin
            e.w = 1'b1; e.a = ha; e.d = hd;
            if (sw) begin
                if (sq.size() < DEPTH) sq.push_back({sa, sd});
                else drop = 1'b1;
            end
        end else if (sq.size() > 0) begin
            h = sq.pop_front();
            e.w = 1'b1; e.a = h[AW+DW-1:DW]; e.d = h[DW-1:0];
            if (sw) sq.push_back({sa, sd});
        end else if (sw) begin
            e.w = 1'b1; e.a = sa; e.d = sd;
        end
        if (clr) begin
            m_c8 = drop ? 8'd1 : 8'd0;
            m_c2 = drop ? 2'd1 : 2'd0;
        end else if (drop) begin
            if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
            if (m_c2 != 2'd3)  m_c2 = m_c2 + 2'd1;
        end
        e.lvl = 3'(sq.size());
        e.ov  = drop;
        e.c8  = m_c8;
        e.c2  = m_c2;
        exp_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("lbo_write", {63'd0, lbo_write}, {63'd0, e.w});
            chk("lbo_addr",  {47'd0, lbo_addr},  {47'd0, e.a});
            chk("lbo_data",  {32'd0, lbo_data},  {32'd0, e.d});
            chk("fifo_level", {61'd0, fifo_level}, {61'd0, e.lvl});
            chk("overflow",  {63'd0, overflow},  {63'd0, e.ov});
            chk("ovf_count", {56'd0, overflow_count}, {56'd0, e.c8});
            chk("ovf_count_cw2", {62'd0, overflow_count2}, {62'd0, e.c2});
            chk("lbo_write_cw2", {63'd0, lbo_write2}, {63'd0, e.w});
            chk("lbo_addr_cw2", {47'd0, lbo_addr2}, {47'd0, e.a});
            chk("lbo_data_cw2", {32'd0, lbo_data2}, {32'd0, e.d});
            chk("level_cw2", {61'd0, fifo_level2}, {61'd0, e.lvl});
            chk("overflow_cw2", {63'd0, overflow2}, {63'd0, e.ov});
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic hs(input int n, input logic [AW-1:0] hbase, input logic [AW-1:0] sbase);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, hbase + AW'(i), 32'hA000_0000 + 32'(i),
                  1'b1, sbase + AW'(i), 32'h5000_0000 + 32'(sbase) + 32'(i), 1'b0);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        exp_q.delete();
        m_c8 = '0;
        m_c2 = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        host_write = 0; host_addr = '0; host_data = '0;
        seq_write = 0; seq_addr = '0; seq_data = '0; overflow_clr = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Bypass with an empty FIFO.
        cycle(1'b0, '0, '0, 1'b1, 17'h00123, 32'hDEADBEEF, 1'b0);
        chk("bypass_addr", {47'd0, lbo_addr}, 64'h123);
        chk("bypass_data", {32'd0, lbo_data}, 64'hDEADBEEF);
        idle();

        // Host and sequencer collide: the sequencer write is deferred by one cycle.
        cycle(1'b1, 17'h00010, 32'h11111111, 1'b1, 17'h00020, 32'h22222222, 1'b0);
        chk("collide_lvl", {61'd0, fifo_level}, 64'd1);
        idle();
        chk("collide_seq_addr", {47'd0, lbo_addr}, 64'h20);
        idle();

        // A host burst of 3 queues S1..S3. They come out after H1..H3.
        hs(3, 17'h00100, 17'h00200);
        chk("burst_peak", {61'd0, fifo_level}, 64'd3);
        repeat (4) idle();

        // Host burst of 6 with a depth-4 FIFO: two sequencer writes are dropped.
        hs(6, 17'h00300, 17'h00400);
        chk("ovf_two", {56'd0, overflow_count}, 64'd2);
        repeat (5) idle();

        // Saturation of the 2-bit counter: 4 queued plus 5 more dropped.
        hs(9, 17'h00500, 17'h00600);
        chk("sat_cw2", {62'd0, overflow_count2}, 64'd3);
        repeat (5) idle();

        // Full FIFO, host idle: a dequeue and an enqueue happen together with no drop.
        hs(4, 17'h00700, 17'h00800);
        cycle(1'b0, '0, '0, 1'b1, 17'h00900, 32'h99990000, 1'b0);
        chk("full_swap_lvl", {61'd0, fifo_level}, 64'd4);
        // A clear in the same cycle as a drop leaves the count at 1.
        hs(1, 17'h00A00, 17'h00B00);
        cycle(1'b1, 17'h00A10, 32'hA0A0A0A0, 1'b1, 17'h00B10, 32'hB0B0B0B0, 1'b1);
        chk("clr_drop_cnt", {56'd0, overflow_count}, 64'd1);
        chk("clr_drop_cnt2", {62'd0, overflow_count2}, 64'd1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        repeat (5) idle();

        // Reset while the FIFO holds 3 entries.
        hs(3, 17'h00C00, 17'h00D00);
        rst_n = 1'b0;
        #1 chk_reset("midrst");
        #1 rst_n = 1'b1;
        model_reset();
        idle();
        idle();

        // Random mix.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), AW'($urandom), $urandom,
                  1'($urandom_range(0, 3) != 0), AW'($urandom), $urandom,
                  1'($urandom_range(0, 9) == 0));
        end
        repeat (6) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lb_write_merge.md
Name: lb_write_merge

Overview:
- Merges two local-bus write streams onto one controlled write bus: host writes (priority) and a sequencer/timing-generator stream (deferrable).
- Sits between the host decoder and the register-space write bus, downstream of the timing generator.
- Replaces "drop and flag collision" with a small FIFO for the sequencer stream.
- Sequencer writes are lost only when that FIFO overflows.

Parameters:
- aw, 17, address width of all buses
- dw, 32, data width of all buses
- fifo_aw, 2, log2 of sequencer FIFO depth (depth = 2^fifo_aw = 4)
- cw, 8, width of saturating overflow counter

Ports:
- clk  input  1  single clock for everything
- rst_n  input  1  asynchronous, active-low reset
- host_data  input  dw  host write data
- host_addr  input  aw  host write address
- host_write  input  1  host write strobe, one transaction per cycle
- seq_data  input  dw  sequencer write data
- seq_addr  input  aw  sequencer write address
- seq_write  input  1  sequencer write strobe
- overflow_clr  input  1  synchronous clear of overflow_count
- lbo_data  output  dw  merged write data (registered)
- lbo_addr  output  aw  merged write address (registered)
- lbo_write  output  1  merged write strobe (registered)
- fifo_level  output  fifo_aw+1  current FIFO occupancy, 0..2^fifo_aw
- overflow  output  1  one-cycle pulse: a sequencer write was dropped
- overflow_count  output  cw  saturating count of dropped sequencer writes

Behaviour:
- Reset (rst_n low, asynchronous): lbo_* = 0, overflow = 0, overflow_count = 0, FIFO empty (fifo_level = 0). All state leaves reset on the first clk edge after rst_n rises.
- Latency: exactly one cycle from an accepted input to lbo_* on the output.
- Idle cycles: lbo_write = 0 and lbo_data = lbo_addr = 0 (no stale values on the bus).
- Per-cycle output selection, in priority order:
  1. host_write = 1: output the host transaction. If seq_write = 1, enqueue the sequencer transaction.
  2. Otherwise, FIFO non-empty: output the FIFO head and dequeue it. If seq_write = 1, enqueue in the same cycle; the level is unchanged.
  3. Otherwise, FIFO empty and seq_write = 1: bypass, output the sequencer transaction directly; the FIFO is not touched.
  4. Otherwise: idle.
- Sequencer ordering is strictly preserved. Bypass is allowed only when the FIFO is empty.
- Full boundary, FIFO full (level = 2^fifo_aw):
  - host_write = 1 and seq_write = 1: the sequencer transaction is dropped. overflow pulses on the next cycle (same cycle the host write appears on lbo) and overflow_count increments.
  - host_write = 0: dequeue and enqueue together, no drop.
- Empty boundary: a dequeue never occurs when empty; level never underflows.
- overflow_count:
  - Saturates at 2^cw-1; no wrap.
  - overflow_clr sets it to 0.
  - overflow_clr in the same cycle as a drop sets it to 1 (the drop is not lost).
- fifo_level is registered and reflects the state after the current cycle's enqueue/dequeue.
- A host burst of N consecutive writes defers the sequencer by up to N cycles. No fairness limit on host bursts; the host owns the priority.
- Reset mid-operation: FIFO contents are discarded, no partial write is emitted, and the bus is idle on the first cycle after reset.

Decomposition:
- No shared package needed. Widths are carried by parameters. Zero-data idle value and priority encoding stay local to the module.
- One sub-module, lb_wfifo: synchronous FIFO of {addr, data}, width aw+dw, depth 2^fifo_aw.
  - Ports: push, pop, din, dout (show-ahead head), level, full, empty; async active-low reset.
  - Same-cycle push+pop when full is legal.
- lb_write_merge holds the selection mux, output registers and overflow logic.

Test Plan:
- Reset check: assert rst_n = 0 mid-stream with FIFO level 3 -> lbo_write = 0, lbo_data = lbo_addr = 0, fifo_level = 0 immediately; first post-reset cycle idle.
- Bypass: seq_write alone, addr 0x00123, data 0xDEADBEEF -> next cycle lbo_write = 1 with addr 0x00123, data 0xDEADBEEF; fifo_level stays 0.
- Collision deferral: host (0x00010, 0x11111111) and seq (0x00020, 0x22222222) in the same cycle -> cycle+1 host on lbo, fifo_level = 1; cycle+2 seq on lbo, fifo_level = 0; no overflow.
- Ordering under burst: host_write held 3 cycles while seq issues S1, S2, S3 -> lbo shows H1 H2 H3 S1 S2 S3 on consecutive cycles; peak fifo_level = 3.
- Overflow: host_write held 6 cycles with seq_write every cycle (depth 4) -> S1..S4 queued, S5 and S6 dropped; overflow pulses twice, overflow_count = 2; then S1..S4 drain in order.
- Counter edges, cw = 2 override:
  - 5 drops -> overflow_count saturates at 3.
  - overflow_clr coincident with a drop -> overflow_count = 1.
